// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encodings and master indices shared by the arbiter and its pick logic.
package mem_arbiter_pkg;

    localparam int ST_W = 2;

    // Encoding 3 is never entered; the FSM folds it into S_IDLE.
    typedef enum logic [ST_W-1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } arb_state_t;

    localparam logic M_INST = 1'b0;
    localparam logic M_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: chooses the winner among pending requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise the data side has fixed priority.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign o_winner = (&i_req) ? ~i_last : i_req[M_DATA];
`else
    // last is tracked by the FSM in both builds but has no say here
    assign o_winner = i_req[M_DATA] | (i_last & 1'b0);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-side and data-side cache units.
// A grant is held while the owner keeps cs high; MEM_ARB_ROUND_ROBIN_EN picks round-robin contention handling.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cs_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_cs_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              s_cs_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,
    output logic [ST_W-1:0]   arb_state
);

    arb_state_t r_state, w_next;
    logic       r_last;
    logic       w_winner, w_g0, w_g1;

    arb_pick u_pick (
        .i_req   ({m1_cs_i, m0_cs_i}),
        .i_last  (r_last),
        .o_winner(w_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= M_DATA;
        end else begin
            r_state <= w_next;
            if (w_next == S_GNT0) r_last <= M_INST;
            else if (w_next == S_GNT1) r_last <= M_DATA;
        end
    end

    // No preemption: the owner keeps the port until it drops cs, then a waiting master takes over directly.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_GNT0:  w_next = m0_cs_i ? S_GNT0 : (m1_cs_i ? S_GNT1 : S_IDLE);
            S_GNT1:  w_next = m1_cs_i ? S_GNT1 : (m0_cs_i ? S_GNT0 : S_IDLE);
            default: w_next = (m0_cs_i | m1_cs_i) ? (w_winner ? S_GNT1 : S_GNT0) : S_IDLE;
        endcase
    end

    // Slave-side mux keyed only on registered state, so cs never feeds the select in the same cycle.
    assign w_g0      = (r_state == S_GNT0);
    assign w_g1      = (r_state == S_GNT1);
    assign s_cs_o    = (w_g0 & m0_cs_i) | (w_g1 & m1_cs_i);
    assign s_we_o    = (w_g0 & m0_we_i) | (w_g1 & m1_we_i);
    assign s_addr_o  = w_g0 ? m0_addr_i : (w_g1 ? m1_addr_i : '0);
    assign s_data_o  = w_g0 ? m0_data_i : (w_g1 ? m1_data_i : '0);
    assign m0_ack_o  = w_g0 & s_ack_i;
    assign m1_ack_o  = w_g1 & s_ack_i;
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign arb_state = r_state;

endmodule
